// File: rtl/gen_worker_axil_slave.sv
// gen_worker_axil_slave: AXI4-Lite slave exposing four 32-bit RW registers to worker logic.
// Define GEN_WORKER_AXIL_STRB_EN to honour WSTRB byte lanes; otherwise every write is full-word.
module gen_worker_axil_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   REG0_O,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   REG1_O,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   REG2_O,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   REG3_O
);
   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int SW = DW / 8;
   typedef enum logic [1:0] {W_IDLE, W_ADDR_HELD, W_DATA_HELD, W_RESP} wstate_e;
   typedef enum logic {R_IDLE, R_DATA} rstate_e;
   wstate_e       wstate_q;
   rstate_e       rstate_q;
   logic          awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
   logic [1:0]    addr_q, wr_idx;
   logic [DW-1:0] data_q, rdata_q, wr_data, mask;
   logic [SW-1:0] strb_q, wr_strb;
   logic [DW-1:0] regs_q [4];
   logic          aw_hs, w_hs, wr_en, unused;
   assign aw_hs   = S_AXI_AWVALID & awready_q;
   assign w_hs    = S_AXI_WVALID & wready_q;
   // Commit on whichever handshake completes the pair; the other half comes from the latch.
   assign wr_en   = (aw_hs & w_hs) | (aw_hs & (wstate_q == W_DATA_HELD)) | (w_hs & (wstate_q == W_ADDR_HELD));
   assign wr_idx  = (wstate_q == W_ADDR_HELD) ? addr_q : S_AXI_AWADDR[3:2];
   assign wr_data = (wstate_q == W_DATA_HELD) ? data_q : S_AXI_WDATA;
   assign wr_strb = (wstate_q == W_DATA_HELD) ? strb_q : S_AXI_WSTRB;
   assign unused  = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], wr_strb};
   always_comb begin
      mask = '1;
`ifdef GEN_WORKER_AXIL_STRB_EN
      for (int b = 0; b < SW; b++) mask[8*b +: 8] = {8{wr_strb[b]}};
`endif
   end
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wstate_q  <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         strb_q    <= '0;
      end else begin
         case (wstate_q)
            W_IDLE: begin
               if (aw_hs) addr_q <= S_AXI_AWADDR[3:2];
               if (w_hs) begin
                  data_q <= S_AXI_WDATA;
                  strb_q <= S_AXI_WSTRB;
               end
               wstate_q  <= (aw_hs && w_hs) ? W_RESP : aw_hs ? W_ADDR_HELD : w_hs ? W_DATA_HELD : W_IDLE;
               awready_q <= !aw_hs;
               wready_q  <= !w_hs;
               bvalid_q  <= aw_hs && w_hs;
            end
            W_ADDR_HELD: if (w_hs) begin
               wstate_q <= W_RESP;
               wready_q <= 1'b0;
               bvalid_q <= 1'b1;
            end
            W_DATA_HELD: if (aw_hs) begin
               wstate_q  <= W_RESP;
               awready_q <= 1'b0;
               bvalid_q  <= 1'b1;
            end
            W_RESP: if (S_AXI_BREADY) begin
               wstate_q  <= W_IDLE;
               awready_q <= 1'b1;
               wready_q  <= 1'b1;
               bvalid_q  <= 1'b0;
            end
         endcase
      end
   end
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) regs_q <= '{default: '0};
      else if (wr_en) regs_q[wr_idx] <= (regs_q[wr_idx] & ~mask) | (wr_data & mask);
   end
   // Capture uses the pre-edge register value, so a same-edge write is not visible.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rstate_q  <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         case (rstate_q)
            R_IDLE: begin
               if (S_AXI_ARVALID && arready_q) begin
                  rdata_q   <= regs_q[S_AXI_ARADDR[3:2]];
                  rstate_q  <= R_DATA;
                  arready_q <= 1'b0;
                  rvalid_q  <= 1'b1;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            R_DATA: if (S_AXI_RREADY) begin
               rstate_q  <= R_IDLE;
               arready_q <= 1'b1;
               rvalid_q  <= 1'b0;
            end
         endcase
      end
   end
   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = 2'b00;
   assign REG0_O        = regs_q[0];
   assign REG1_O        = regs_q[1];
   assign REG2_O        = regs_q[2];
   assign REG3_O        = regs_q[3];
endmodule

// File: tb/tb_gen_worker_axil_slave.sv
// tb_gen_worker_axil_slave: directed checks of the AXI4-Lite register slave.
module tb_gen_worker_axil_slave;
   logic        clk = 0, rst_n = 0;
   logic [3:0]  awaddr = 0, araddr = 0, wstrb = 4'hF;
   logic [2:0]  awprot = 0, arprot = 0;
   logic        awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
   logic [31:0] wdata = 0;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata, reg0, reg1, reg2, reg3;
   int          total = 0, bad = 0;

   gen_worker_axil_slave dut (
      .ACLK(clk), .ARESETN(rst_n),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .REG0_O(reg0), .REG1_O(reg1), .REG2_O(reg2), .REG3_O(reg3)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input string tag);
      int n = 0;
      @(negedge clk);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
      while (!(awready && wready) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_tmo"}, 32'(n < 20), 1);
      @(negedge clk);
      awvalid = 0; wvalid = 0;
      chk({tag, "_bv"}, bvalid, 1);
      chk({tag, "_bresp"}, bresp, 0);
      @(negedge clk);
      chk({tag, "_bclr"}, bvalid, 0);
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
      int n = 0;
      @(negedge clk);
      araddr = a; arvalid = 1;
      while (!arready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_tmo"}, 32'(n < 20), 1);
      @(negedge clk);
      arvalid = 0;
      chk({tag, "_rv"}, rvalid, 1);
      chk({tag, "_rresp"}, rresp, 0);
      chk(tag, rdata, exp);
      @(negedge clk);
      chk({tag, "_rclr"}, rvalid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_awrdy", awready, 0);
      chk("rst_wrdy", wready, 0);
      chk("rst_arrdy", arready, 0);
      chk("rst_bv", bvalid, 0);
      chk("rst_rv", rvalid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_reg0", reg0, 0);
      rst_n = 1;
      @(negedge clk);
      chk("rel_awrdy", awready, 1);
      chk("rel_wrdy", wready, 1);
      chk("rel_arrdy", arready, 1);

      for (int i = 0; i < 4; i++) wr(4'(i * 4), 32'(i + 1), 4'hF, "wr_basic");
      for (int i = 0; i < 4; i++) rd(4'(i * 4), 32'(i + 1), "rd_basic");
      chk("reg3_basic", reg3, 4);

      // address three cycles ahead of data
      @(negedge clk);
      awaddr = 4'h8; awvalid = 1;
      @(negedge clk);
      awvalid = 0;
      for (int i = 0; i < 3; i++) begin
         chk("aw_first_awrdy", awready, 0);
         chk("aw_first_wrdy", wready, 1);
         chk("aw_first_bv", bvalid, 0);
         if (i < 2) @(negedge clk);
      end
      wdata = 32'hDEADBEEF; wvalid = 1;
      @(negedge clk);
      wvalid = 0;
      chk("aw_first_reg2", reg2, 32'hDEADBEEF);
      chk("aw_first_bv2", bvalid, 1);
      @(negedge clk);
      chk("aw_first_awrdy2", awready, 1);

      // response back-pressure with a second write waiting
      bready = 0;
      @(negedge clk);
      awaddr = 4'h0; wdata = 32'h55; awvalid = 1; wvalid = 1;
      @(negedge clk);
      awaddr = 4'h4; wdata = 32'h66;
      for (int i = 0; i < 5; i++) begin
         chk("bp_bv", bvalid, 1);
         chk("bp_awrdy", awready, 0);
         chk("bp_wrdy", wready, 0);
         chk("bp_reg1", reg1, 2);
         @(negedge clk);
      end
      bready = 1;
      @(negedge clk);
      chk("bp_bclr", bvalid, 0);
      chk("bp_reg1_hold", reg1, 2);
      @(negedge clk);
      awvalid = 0; wvalid = 0;
      chk("bp_reg1_new", reg1, 32'h66);
      chk("bp_reg0", reg0, 32'h55);
      chk("bp_bv2", bvalid, 1);
      @(negedge clk);
      chk("bp_bclr2", bvalid, 0);

      wr(4'h0, 32'h11223344, 4'hF, "strb_init");
      wr(4'h0, 32'hAABBCCDD, 4'b0101, "strb_wr");
`ifdef GEN_WORKER_AXIL_STRB_EN
      rd(4'h0, 32'h11BB33DD, "strb_rd");
`else
      rd(4'h0, 32'hAABBCCDD, "strb_rd");
`endif

      // read stall plus same-edge write to the same register
      rready = 0;
      @(negedge clk);
      araddr = 4'h4; arvalid = 1;
      awaddr = 4'h4; wdata = 32'h77; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      @(negedge clk);
      arvalid = 0; awvalid = 0; wvalid = 0;
      chk("rs_reg1", reg1, 32'h77);
      for (int i = 0; i < 4; i++) begin
         chk("rs_rdata", rdata, 32'h66);
         chk("rs_rv", rvalid, 1);
         chk("rs_arrdy", arready, 0);
         @(negedge clk);
      end
      rready = 1;
      @(negedge clk);
      chk("rs_rclr", rvalid, 0);
      chk("rs_arrdy2", arready, 1);
      rd(4'h4, 32'h77, "rs_rd_new");

      // reset while write address held and read response pending
      rready = 0;
      @(negedge clk);
      awaddr = 4'hC; awvalid = 1; araddr = 4'h0; arvalid = 1;
      @(negedge clk);
      awvalid = 0; arvalid = 0;
      chk("mr_rv", rvalid, 1);
      chk("mr_awrdy", awready, 0);
      chk("mr_wrdy", wready, 1);
      #2 rst_n = 0;
      #1;
      chk("mr_rv0", rvalid, 0);
      chk("mr_bv0", bvalid, 0);
      chk("mr_awrdy0", awready, 0);
      chk("mr_wrdy0", wready, 0);
      chk("mr_arrdy0", arready, 0);
      chk("mr_regs", reg0 | reg1 | reg2 | reg3, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1; rready = 1;
      wr(4'h4, 32'h99, 4'hF, "mr_wr");
      rd(4'h4, 32'h99, "mr_rd1");
      rd(4'hC, 32'h0, "mr_rd3");
      rd(4'h0, 32'h0, "mr_rd0");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/gen_worker_axil_slave.md
GEN_WORKER_AXIL_SLAVE -- requirements
Module: gen_worker_axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data bus width; only 32 supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width; bits [3:2] select the register.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: ACLK  in  1  sole clock, all state on rising edge.
REQ-004 ARESETN  in  1  asynchronous active-low reset.
REQ-005 S_AXI_AWADDR  in  4  write address; S_AXI_AWPROT  in  3  ignored; S_AXI_AWVALID  in  1; S_AXI_AWREADY  out  1.
REQ-006 S_AXI_WDATA  in  32  write data; S_AXI_WSTRB  in  4  byte strobes; S_AXI_WVALID  in  1; S_AXI_WREADY  out  1.
REQ-007 S_AXI_BRESP  out  2  write response; S_AXI_BVALID  out  1; S_AXI_BREADY  in  1.
REQ-008 S_AXI_ARADDR  in  4  read address; S_AXI_ARPROT  in  3  ignored; S_AXI_ARVALID  in  1; S_AXI_ARREADY  out  1.
REQ-009 S_AXI_RDATA  out  32; S_AXI_RRESP  out  2; S_AXI_RVALID  out  1; S_AXI_RREADY  in  1.
REQ-010 REG0_O..REG3_O  out  32 each  live register contents to worker logic.

Function
REQ-011 SHALL implement four 32-bit RW registers at byte offsets 0x0, 0x4, 0x8, 0xC; AWADDR/ARADDR[1:0] ignored.
REQ-012 Write FSM SHALL have states W_IDLE, W_ADDR_HELD, W_DATA_HELD, W_RESP.
REQ-013 AWREADY SHALL be 1 in W_IDLE and W_DATA_HELD, else 0; WREADY SHALL be 1 in W_IDLE and W_ADDR_HELD, else 0.
REQ-014 W_IDLE: AW-only handshake -> W_ADDR_HELD (address latched); W-only -> W_DATA_HELD (data, strobes latched); both same cycle -> W_RESP.
REQ-015 Register update SHALL occur on the edge completing the second of the AW/W handshakes, using latched or live values as applicable.
REQ-016 BVALID SHALL assert the cycle after that edge with BRESP=2'b00 and hold until BVALID&BREADY, then FSM -> W_IDLE.
REQ-017 Read FSM SHALL have states R_IDLE (ARREADY=1) and R_DATA (ARREADY=0, RVALID=1).
REQ-018 On ARVALID&ARREADY, RDATA SHALL be captured from the addressed register and FSM -> R_DATA; RRESP=2'b00.
REQ-019 RDATA/RVALID SHALL hold stable until RVALID&RREADY, then -> R_IDLE; max one read per 2 cycles.
REQ-020 Read and write channels SHALL be independent; a read handshake coinciding with the write-commit edge to the same register SHALL return the pre-write value.
REQ-021 No response SHALL ever be SLVERR or DECERR.

Reset
REQ-022 ARESETN low SHALL asynchronously force all four registers to 0, REG*_O=0, FSMs to W_IDLE/R_IDLE.
REQ-023 During reset: AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0; readies go to 1 the first cycle after deassertion.
REQ-024 Reset mid-transaction SHALL discard latched address/data and pending responses; no register SHALL be partially updated.

Configuration
REQ-025 Macro GEN_WORKER_AXIL_STRB_EN: defined -> each byte lane updates only where WSTRB bit is 1; WSTRB=0 completes with OKAY and no change.
REQ-026 Undefined -> WSTRB ignored, every write updates the full 32 bits.

Verification
REQ-027 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC with AW/W together, BREADY=1 -> each BVALID one cycle after handshake, BRESP=0; readback returns 0x1..0x4.
REQ-028 AWVALID to 0x8 three cycles before WVALID data 0xDEADBEEF -> WREADY stays 1, AWREADY 0 meanwhile; REG2_O=0xDEADBEEF after W handshake.
REQ-029 BREADY held low 5 cycles after write -> BVALID held, AWREADY=WREADY=0 throughout; next write accepted only after B handshake.
REQ-030 With GEN_WORKER_AXIL_STRB_EN: reg0=0x11223344, write 0xAABBCCDD with WSTRB=4'b0101 -> reads 0x11BB33DD; without macro -> 0xAABBCCDD.
REQ-031 Read 0x4 with RREADY low 4 cycles -> RDATA stable, ARREADY=0 until RREADY; write to 0x4 on same edge as AR -> old value returned.
REQ-032 Assert ARESETN=0 while W_ADDR_HELD and RVALID=1 -> BVALID/RVALID/readies drop immediately, all REG*_O=0, clean transfers after release.
